// File: rtl/quad_step_gen.sv
// Quadrature step generator: emits a programmed number of A/B edges at a fixed
// half-period, with direction control, abort, and a decoder-style position count.
module quad_step_gen (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmdValid,
  output logic        cmdReady,
  input  logic        cmdDir,
  input  logic [7:0]  cmdSteps,
  input  logic [15:0] halfPeriod,
  input  logic        abort,
  output logic        a,
  output logic        b,
  output logic        busy,
  output logic        done,
  output logic [9:0]  position
);

  typedef enum logic [1:0] {StIdle, StRun, StFinish} state_e;

  state_e      state_q;
  logic        dir_q;
  logic [7:0]  steps_q;
  logic [15:0] hp_q;
  logic [15:0] div_q;
  logic [9:0]  pos_q;
  logic        a_q, b_q;
  logic        done_q, busy_q, ready_q;

  logic        edge_due;
  logic [9:0]  pos_next;

  always_comb begin
    edge_due = (div_q == (hp_q - 16'd1));
    pos_next = dir_q ? (pos_q + 10'd1) : (pos_q - 10'd1);
  end

  // Phase is pos mod 4; (a,b) = 00,10,11,01 for phase 0..3.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      dir_q   <= 1'b0;
      steps_q <= 8'd0;
      hp_q    <= 16'd1;
      div_q   <= 16'd0;
      pos_q   <= 10'd0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (cmdValid) begin
            dir_q   <= cmdDir;
            steps_q <= cmdSteps;
            hp_q    <= (halfPeriod == 16'd0) ? 16'd1 : halfPeriod;
            div_q   <= 16'd0;
            ready_q <= 1'b0;
            if (cmdSteps == 8'd0) begin
              state_q <= StFinish;
            end else begin
              state_q <= StRun;
              busy_q  <= 1'b1;
            end
          end
        end
        StRun: begin
          if (edge_due) begin
            div_q   <= 16'd0;
            pos_q   <= pos_next;
            a_q     <= pos_next[1] ^ pos_next[0];
            b_q     <= pos_next[1];
            steps_q <= steps_q - 8'd1;
          end else begin
            div_q <= div_q + 16'd1;
          end
          // An edge falling in the abort cycle is still emitted above.
          if (abort || (edge_due && (steps_q == 8'd1))) begin
            state_q <= StFinish;
            busy_q  <= 1'b0;
          end
        end
        StFinish: begin
          // First FINISH cycle raises done; second returns to IDLE.
          if (!done_q) begin
            done_q <= 1'b1;
          end else begin
            state_q <= StIdle;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign cmdReady = ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign a        = a_q;
  assign b        = b_q;
  assign position = pos_q;

endmodule

// File: tb/tb_quad_step_gen.sv
// Bench for quad_step_gen: timeline-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_quad_step_gen;

  logic        clk;
  logic        reset;
  logic        cmdValid;
  logic        cmdReady;
  logic        cmdDir;
  logic [7:0]  cmdSteps;
  logic [15:0] halfPeriod;
  logic        abort;
  logic        a, b, busy, done;
  logic [9:0]  position;

  quad_step_gen dut (
    .clk        (clk),
    .reset      (reset),
    .cmdValid   (cmdValid),
    .cmdReady   (cmdReady),
    .cmdDir     (cmdDir),
    .cmdSteps   (cmdSteps),
    .halfPeriod (halfPeriod),
    .abort      (abort),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .position   (position)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  function automatic logic [1:0] phase_ab(input int p);
    case (p % 4)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  // Reference model: a command accepted at edge t0 with half-period h and n steps
  // produces edges at t0+h, t0+2h, ... until t0+n*h or an abort edge (fin);
  // done follows at fin+1, ready returns at fin+2.
  int cyc = 0;
  bit m_on = 0, m_ready = 0, m_active = 0, m_done = 0, m_dir = 0;
  int m_t0 = 0, m_hp = 1, m_fin = -10, m_pos = 0;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (reset === 1'b1) begin
        m_on = 1; m_ready = 1; m_active = 0; m_done = 0; m_pos = 0; m_fin = -10;
      end else if (m_on) begin
        m_done = 0;
        if (m_ready) begin
          if (cmdValid) begin
            m_ready = 0;
            m_t0    = cyc;
            m_hp    = (halfPeriod == 16'd0) ? 1 : int'(halfPeriod);
            m_dir   = cmdDir;
            if (cmdSteps == 8'd0) m_fin = cyc;
            else begin
              m_active = 1;
              m_fin    = cyc + int'(cmdSteps) * m_hp;
            end
          end
        end else if (m_active) begin
          if ((cyc - m_t0) % m_hp == 0) m_pos = (m_pos + (m_dir ? 1 : 1023)) % 1024;
          if (abort || cyc == m_fin) begin
            m_fin    = cyc;
            m_active = 0;
          end
        end else begin
          if (cyc == m_fin + 1) m_done = 1;
          else if (cyc == m_fin + 2) m_ready = 1;
        end
      end
    end
  end

  // Per-cycle compare against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (m_on) begin
        check("model_ab", {30'd0, a, b}, {30'd0, phase_ab(m_pos)});
        check("model_pos", {22'd0, position}, m_pos);
        check("model_busy", {31'd0, busy}, {31'd0, m_active});
        check("model_done", {31'd0, done}, {31'd0, m_done});
        check("model_ready", {31'd0, cmdReady}, {31'd0, m_ready});
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      if (done === 1'b1) done_cnt++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
  endtask

  // Returns in the cycle right after the accept edge (cycle 0).
  task automatic send(input bit dir, input int steps, input int hp);
    int w;
    w = 0;
    @(negedge clk);
    while (cmdReady !== 1'b1 && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (w >= 300) check("ready_wait", 32'd0, 32'd1);
    cmdValid   = 1'b1;
    cmdDir     = dir;
    cmdSteps   = steps[7:0];
    halfPeriod = hp[15:0];
    @(negedge clk);
    cmdValid = 1'b0;
  endtask

  int dc0;

  initial begin
    reset = 1'b0; cmdValid = 1'b0; cmdDir = 1'b0; cmdSteps = 8'd0;
    halfPeriod = 16'd1; abort = 1'b0;

    // Reset state and forward 4 steps at half-period 3.
    do_reset();
    check("rst_pos", {22'd0, position}, 32'd0);
    check("rst_ab", {30'd0, a, b}, 32'd0);
    check("rst_ready", {31'd0, cmdReady}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    send(1'b1, 4, 3);
    cycles(2); check("s1_c2_ab", {30'd0, a, b}, 32'd0);
    cycles(1); check("s1_c3_ab", {30'd0, a, b}, 32'b10);
    cycles(3); check("s1_c6_ab", {30'd0, a, b}, 32'b11);
    cycles(3); check("s1_c9_ab", {30'd0, a, b}, 32'b01);
    cycles(3); check("s1_c12_ab", {30'd0, a, b}, 32'b00);
    check("s1_c12_pos", {22'd0, position}, 32'd4);
    check("s1_c12_done", {31'd0, done}, 32'd0);
    check("s1_c12_busy", {31'd0, busy}, 32'd0);
    cycles(1); check("s1_c13_done", {31'd0, done}, 32'd1);
    check("s1_c13_ready", {31'd0, cmdReady}, 32'd0);
    cycles(1); check("s1_c14_ready", {31'd0, cmdReady}, 32'd1);
    check("s1_c14_done", {31'd0, done}, 32'd0);

    // Reverse 2 steps from 0, then forward across the 1023 -> 0 wrap.
    do_reset();
    send(1'b0, 2, 1);
    cycles(1); check("s2_ab1", {30'd0, a, b}, 32'b01);
    check("s2_pos1", {22'd0, position}, 32'd1023);
    cycles(1); check("s2_ab2", {30'd0, a, b}, 32'b11);
    check("s2_pos2", {22'd0, position}, 32'd1022);
    send(1'b1, 3, 1);
    cycles(2); check("s2_wrap_pos", {22'd0, position}, 32'd0);
    check("s2_wrap_ab", {30'd0, a, b}, 32'b00);

    // Zero-step command: no edge, done one cycle later, ready after two.
    send(1'b1, 0, 7);
    check("s3_c0_ready", {31'd0, cmdReady}, 32'd0);
    check("s3_c0_ab", {30'd0, a, b}, 32'b10);
    cycles(1); check("s3_c1_done", {31'd0, done}, 32'd1);
    check("s3_c1_ab", {30'd0, a, b}, 32'b10);
    cycles(1); check("s3_c2_ready", {31'd0, cmdReady}, 32'd1);
    check("s3_c2_pos", {22'd0, position}, 32'd1);

    // Abort mid-run: only the edges at cycles 5 and 10 happen.
    do_reset();
    dc0 = done_cnt;
    send(1'b1, 10, 5);
    cycles(12);
    abort = 1'b1;
    cycles(1);
    abort = 1'b0;
    check("s4_busy", {31'd0, busy}, 32'd0);
    cycles(20);
    check("s4_pos", {22'd0, position}, 32'd2);
    check("s4_ab", {30'd0, a, b}, 32'b11);
    check("s4_done_cnt", done_cnt - dc0, 32'd1);

    // halfPeriod 0 behaves as 1.
    do_reset();
    send(1'b1, 3, 0);
    cycles(1); check("s5_pos1", {22'd0, position}, 32'd1);
    cycles(1); check("s5_pos2", {22'd0, position}, 32'd2);
    cycles(1); check("s5_pos3", {22'd0, position}, 32'd3);

    // Reset during RUN with a pending cmdValid held high.
    do_reset();
    dc0 = done_cnt;
    send(1'b1, 5, 4);
    cmdValid = 1'b1; cmdDir = 1'b0; cmdSteps = 8'd3; halfPeriod = 16'd1;
    cycles(4);
    check("s6_pos_run", {22'd0, position}, 32'd1);
    check("s6_busy_run", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    check("s6_rst_pos", {22'd0, position}, 32'd0);
    check("s6_rst_ab", {30'd0, a, b}, 32'd0);
    check("s6_rst_ready", {31'd0, cmdReady}, 32'd1);
    check("s6_rst_done", {31'd0, done}, 32'd0);
    check("s6_no_done", done_cnt - dc0, 32'd0);
    cycles(1);
    cmdValid = 1'b0;
    check("s6_acc_busy", {31'd0, busy}, 32'd1);
    cycles(8);
    check("s6_pos_end", {22'd0, position}, 32'd1021);
    check("s6_done_cnt", done_cnt - dc0, 32'd1);

    // Randomized traffic, including halfPeriod changes and aborts during RUN.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      cmdValid   = ($urandom % 4) == 0;
      cmdDir     = $urandom % 2;
      cmdSteps   = (($urandom % 16) == 0) ? 8'($urandom_range(100, 255))
                                          : 8'($urandom_range(0, 12));
      halfPeriod = 16'($urandom_range(0, 3));
      abort      = ($urandom % 24) == 0;
      reset      = ($urandom % 300) == 0;
    end
    @(negedge clk);
    cmdValid = 1'b0; abort = 1'b0; reset = 1'b0;
    cycles(10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
